branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with one 2-bit saturating direction counter per entry. The fetch stage looks up the current PC every cycle and receives a predicted direction and next PC. The execute stage returns each resolved conditional branch (actual taken/not-taken from the branch decision logic, plus the computed target) through the update port to train the table. Two saturating statistics counters track resolved branches and correct direction predictions.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, 2..256; INDEX_BITS = log2(ENTRIES)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- lookup_pc  input  32  fetch-stage PC (word aligned; bits [1:0] ignored)
- predict_taken  output  1  1 = predicted taken
- predict_target  output  32  predicted next PC
- update_valid  input  1  a conditional branch resolved in execute this cycle
- update_pc  input  32  PC of the resolved branch
- update_taken  input  1  actual outcome, 1 = taken
- update_target  input  32  actual branch target address (valid when update_taken = 1)
- stat_updates  output  16  number of accepted updates, saturating
- stat_correct  output  16  number of updates whose direction was predicted correctly, saturating

## Operation
- Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]. Each entry: valid, tag, target[31:0], ctr[1:0].
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; predicts taken when ctr[1] = 1.
- Lookup (combinational from stored state):
  - hit = valid and tag match
  - predict_taken = hit and ctr[1]
  - predict_target = entry target when predict_taken = 1, otherwise lookup_pc + 4 (32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000)
- Update, when update_valid = 1, applied at the clock edge:
  - Hit: ctr increments on taken and decrements on not-taken, saturating at 11 and 00. Target is overwritten with update_target when taken and unchanged when not taken.
  - Miss, taken: allocate the entry, overwriting any previous occupant including a valid alias. Set valid = 1, tag, target = update_target, ctr = 10.
  - Miss, not taken: no table change.
- Statistics, when update_valid = 1:
  - stat_updates increments.
  - stat_correct increments when (hit and ctr[1]) equals update_taken, evaluated on pre-update state. A not-taken miss counts as correct.
  - Both counters saturate at 0xFFFF.
- update_valid = 0: no state changes; update_* values are don't-care.

## Timing
- Lookup latency 0 cycles: outputs follow lookup_pc and stored state in the same cycle.
- Update latency 1 cycle: the new entry state is visible to lookups on the cycle after update_valid.
- Lookup and update on the same index in the same cycle: the lookup sees the old state. There is no bypass.
- reset = 1 at an edge:
  - all valid bits, counters and targets are cleared; stat_updates = stat_correct = 0
  - any update presented in that cycle is discarded
  - after reset, predict_taken = 0 and predict_target = lookup_pc + 4
- Reset applies mid-training with the same effect; there is no partial state.
- Only one update is accepted per cycle; the execute stage never presents more than one.

## Test plan
- Reset: hold reset 1 cycle, lookup_pc = 0x100 -> predict_taken = 0, predict_target = 0x104, stat_updates = stat_correct = 0.
- Allocation: update pc 0x100, taken, target 0x080 -> in the same cycle predict_taken = 0. Next cycle lookup 0x100 -> predict_taken = 1, target 0x080, stat_updates = 1, stat_correct = 0.
- Saturation/hysteresis: after allocation, apply 3 more taken updates to 0x100 (ctr stays at 11), then 1 not-taken -> still taken. A second not-taken -> ctr = 01, predict_taken = 0, predict_target = 0x104.
- Aliasing (ENTRIES = 16): 0x100 allocated with target 0x080, then update 0x140 taken target 0x200 -> lookup 0x140 predicts 0x200; lookup 0x100 -> predict_taken = 0, target 0x104.
- Not-taken miss: update 0x300 not taken -> no allocation, lookup 0x300 not taken, stat_updates +1, stat_correct +1. Lookup 0xFFFFFFFC -> target 0x00000000.
- Reset mid-operation: with several valid entries and stats = 5/3, assert reset together with update_valid -> all lookups not taken, stats 0, the update is not applied.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup is purely combinational from stored state; a
// resolved branch trains the table on the following clock edge. Two saturating
// counters track resolved branches and correct direction predictions.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  output logic [15:0] stat_updates,
  output logic [15:0] stat_correct
);

  localparam int unsigned IndexBits = $clog2(ENTRIES);
  localparam int unsigned TagBits   = 30 - IndexBits;

  logic                 valid_q  [ENTRIES];
  logic [TagBits-1:0]   tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [15:0] stat_updates_q, stat_updates_d;
  logic [15:0] stat_correct_q, stat_correct_d;

  logic [IndexBits-1:0] lk_idx;
  logic [TagBits-1:0]   lk_tag;
  logic                 lk_hit;

  logic [IndexBits-1:0] up_idx;
  logic [TagBits-1:0]   up_tag;
  logic                 up_hit;
  logic                 up_pred_taken;
  logic                 up_correct;
  logic [1:0]           up_ctr_next;

  assign lk_idx = lookup_pc[IndexBits+1:2];
  assign lk_tag = lookup_pc[31:IndexBits+2];
  assign up_idx = update_pc[IndexBits+1:2];
  assign up_tag = update_pc[31:IndexBits+2];

  // Fetch-side prediction; falls through to the sequential PC unless taken.
  always_comb begin
    lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_taken  = lk_hit && ctr_q[lk_idx][1];
    predict_target = predict_taken ? target_q[lk_idx] : (lookup_pc + 32'd4);
  end

  // Resolve-side view of the pre-update entry and its trained counter value.
  always_comb begin
    up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred_taken = up_hit && ctr_q[up_idx][1];
    up_correct    = (up_pred_taken == update_taken);
    up_ctr_next   = ctr_q[up_idx];
    if (update_taken) begin
      if (ctr_q[up_idx] != 2'b11) up_ctr_next = ctr_q[up_idx] + 2'd1;
    end else begin
      if (ctr_q[up_idx] != 2'b00) up_ctr_next = ctr_q[up_idx] - 2'd1;
    end
  end

  // Table training: hits move the counter, taken misses allocate (evicting aliases).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (update_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (update_taken) target_q[up_idx] <= update_target;
      end else if (update_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Saturating statistics next-state.
  always_comb begin
    stat_updates_d = stat_updates_q;
    stat_correct_d = stat_correct_q;
    if (update_valid) begin
      if (stat_updates_q != 16'hFFFF) stat_updates_d = stat_updates_q + 16'd1;
      if (up_correct && (stat_correct_q != 16'hFFFF)) stat_correct_d = stat_correct_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates_q <= '0;
      stat_correct_q <= '0;
    end else begin
      stat_updates_q <= stat_updates_d;
      stat_correct_q <= stat_correct_d;
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_correct = stat_correct_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against the DUT outputs of that cycle.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [15:0] stat_updates;
  logic [15:0] stat_correct;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_pc      (lookup_pc),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target),
    .stat_updates   (stat_updates),
    .stat_correct   (stat_correct)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [15:0] updates;
    logic [15:0] correct;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against this cycle's outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (predict_taken !== e.taken) begin
        failures++;
        $display("FAIL %s predict_taken got=%0b want=%0b", n, predict_taken, e.taken);
      end
      checks++;
      if (predict_target !== e.target) begin
        failures++;
        $display("FAIL %s predict_target got=%08h want=%08h", n, predict_target, e.target);
      end
      checks++;
      if (stat_updates !== e.updates) begin
        failures++;
        $display("FAIL %s stat_updates got=%0d want=%0d", n, stat_updates, e.updates);
      end
      checks++;
      if (stat_correct !== e.correct) begin
        failures++;
        $display("FAIL %s stat_correct got=%0d want=%0d", n, stat_correct, e.correct);
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge.
  task automatic step(input logic rst, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic [31:0] lpc);
    @(posedge clk);
    #1;
    reset         = rst;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utg;
    lookup_pc     = lpc;
  endtask

  task automatic expect_out(input string n, input logic t, input logic [31:0] tg,
                            input logic [15:0] u, input logic [15:0] c);
    exp_t e;
    e.taken   = t;
    e.target  = tg;
    e.updates = u;
    e.correct = c;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    reset         = 1'b1;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_target = '0;
    lookup_pc     = 32'h100;

    // Reset edge, then allocate 0x100 -> 0x080 while looking it up.
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h080, 32'h100);
    expect_out("reset_and_alloc_same_cycle", 1'b0, 32'h104, 16'd0, 16'd0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h080, 32'h100);
    expect_out("alloc_visible", 1'b1, 32'h080, 16'd1, 16'd0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h0C0, 32'h100);
    expect_out("train_t2", 1'b1, 32'h080, 16'd2, 16'd1);
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h0C0, 32'h100);
    expect_out("train_t3", 1'b1, 32'h0C0, 16'd3, 16'd2);
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
    expect_out("first_nt", 1'b1, 32'h0C0, 16'd4, 16'd3);
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
    expect_out("hysteresis_still_t", 1'b1, 32'h0C0, 16'd5, 16'd3);
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h080, 32'h100);
    expect_out("weak_nt", 1'b0, 32'h104, 16'd6, 16'd3);

    // Alias: 0x140 shares index 0 with 0x100.
    step(1'b0, 1'b1, 32'h140, 1'b1, 32'h200, 32'h100);
    expect_out("retrained_0x100", 1'b1, 32'h080, 16'd7, 16'd3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h140);
    expect_out("alias_new", 1'b1, 32'h200, 16'd8, 16'd3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    expect_out("alias_evicted", 1'b0, 32'h104, 16'd8, 16'd3);

    // Not-taken miss does not allocate nor disturb the alias occupant.
    step(1'b0, 1'b1, 32'h300, 1'b0, 32'h999, 32'h300);
    expect_out("nt_miss_same_cycle", 1'b0, 32'h304, 16'd8, 16'd3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h300);
    expect_out("nt_miss_no_alloc", 1'b0, 32'h304, 16'd9, 16'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h140);
    expect_out("nt_miss_kept_alias", 1'b1, 32'h200, 16'd9, 16'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    expect_out("pc_wrap", 1'b0, 32'h0000_0000, 16'd9, 16'd4);

    // Second entry, then reset with an update presented in the same cycle.
    step(1'b0, 1'b1, 32'h204, 1'b1, 32'h400, 32'h204);
    expect_out("alloc_idx1_same_cycle", 1'b0, 32'h208, 16'd9, 16'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h204);
    expect_out("alloc_idx1", 1'b1, 32'h400, 16'd10, 16'd4);
    step(1'b1, 1'b1, 32'h208, 1'b1, 32'h500, 32'h204);
    expect_out("reset_cycle_old_state", 1'b1, 32'h400, 16'd10, 16'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h208);
    expect_out("reset_update_dropped", 1'b0, 32'h20C, 16'd0, 16'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h204);
    expect_out("reset_cleared_idx1", 1'b0, 32'h208, 16'd0, 16'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h140);
    expect_out("reset_cleared_idx0", 1'b0, 32'h144, 16'd0, 16'd0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
